// File: rtl/tfcall_sum_pipe_if.sv
// rtl/tfcall_sum_pipe_if.sv - operand/result handshake bundle for tfcall_sum_pipe
interface tfcall_sum_pipe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             op;
  logic [LANES*WIDTH-1:0] x;
  logic [LANES*WIDTH-1:0] y;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] result;
  logic                   ovf;
  logic [15:0]            count;

  // producer of operands / consumer of results
  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, result, ovf, count
  );

  // the pipeline itself
  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, result, ovf, count
  );
endinterface

// File: rtl/tfcall_sum_pipe.sv
// rtl/tfcall_sum_pipe.sv - two-stage multi-lane sum/double/const/acc pipeline (option: TFCALL_SAT_EN)
module tfcall_sum_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst,
  tfcall_sum_pipe_if.slave   bus
);
  localparam logic [1:0] OP_SUM    = 2'd0;
  localparam logic [1:0] OP_DOUBLE = 2'd1;
  localparam logic [1:0] OP_CONST  = 2'd2;
  localparam logic [1:0] OP_ACC    = 2'd3;

  logic                   s1_valid;
  logic [1:0]             s1_op;
  logic [LANES*WIDTH-1:0] s1_x;
  logic [LANES*WIDTH-1:0] s1_y;
  logic                   s2_valid;
  logic [LANES*WIDTH-1:0] s2_result;
  logic [WIDTH-1:0]       acc [LANES];
  logic                   ovf_q;
  logic [15:0]            count_q;

  logic                   s1_adv;
  logic                   s2_adv;
  logic [WIDTH:0]         wide [LANES];
  logic [LANES*WIDTH-1:0] calc_result;
  logic [LANES-1:0]       lane_ovf;

  // One lane's arithmetic, carried one bit wider so the carry-out is the overflow.
  function automatic logic [WIDTH:0] lane_calc(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] acc_v);
    case (op)
      OP_SUM:    return {1'b0, a} + {1'b0, b};
      OP_DOUBLE: return {a, 1'b0};
      OP_CONST:  return {{WIDTH{1'b0}}, 1'b1};
      default:   return {1'b0, acc_v} + {1'b0, a};
    endcase
  endfunction

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.ovf       = ovf_q;
  assign bus.count     = count_q;

  // Per-lane result of the beat sitting in S1, folded to WIDTH bits.
  always_comb begin
    calc_result = '0;
    lane_ovf    = '0;
    for (int i = 0; i < LANES; i++) begin
      wide[i] = lane_calc(s1_op, s1_x[i*WIDTH +: WIDTH], s1_y[i*WIDTH +: WIDTH], acc[i]);
      lane_ovf[i] = wide[i][WIDTH];
`ifdef TFCALL_SAT_EN
      calc_result[i*WIDTH +: WIDTH] = wide[i][WIDTH] ? {WIDTH{1'b1}} : wide[i][WIDTH-1:0];
`else
      calc_result[i*WIDTH +: WIDTH] = wide[i][WIDTH-1:0];
`endif
    end
  end

  // Pipeline registers, accumulators, sticky overflow and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_SUM;
      s1_x      <= '0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= calc_result;
          if (|lane_ovf) ovf_q <= 1'b1;
          if (s1_op == OP_ACC) begin
            for (int i = 0; i < LANES; i++) acc[i] <= calc_result[i*WIDTH +: WIDTH];
          end
        end
      end
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op <= bus.op;
          s1_x  <= bus.x;
          s1_y  <= bus.y;
        end
      end
      if (s2_valid && bus.out_ready) count_q <= count_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_tfcall_sum_pipe.sv
// tb/tb_tfcall_sum_pipe.sv - scoreboard bench for tfcall_sum_pipe
module tb_tfcall_sum_pipe;
  localparam int W = 8;
  localparam int L = 2;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    logic [L*W-1:0] res;
    logic           ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tfcall_sum_pipe_if #(.WIDTH(W), .LANES(L)) bif ();

  tfcall_sum_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  int          macc [L];
  logic        mdl_ovf = 1'b0;
  logic [15:0] n_out = 16'd0;
  logic        in_fired = 1'b0;
  logic [L*W-1:0] last_result = '0;

  // Reference model: evaluate an accepted beat in integer arithmetic.
  task automatic model_push(input logic [1:0] op, input logic [L*W-1:0] xv, input logic [L*W-1:0] yv);
    exp_t e;
    int a, b, s;
    e.res = '0;
    for (int i = 0; i < L; i++) begin
      a = int'(xv[i*W +: W]);
      b = int'(yv[i*W +: W]);
      case (op)
        2'd0: s = a + b;
        2'd1: s = a * 2;
        2'd2: s = 1;
        default: s = macc[i] + a;
      endcase
      if (s > MAXV) begin
        mdl_ovf = 1'b1;
`ifdef TFCALL_SAT_EN
        s = MAXV;
`else
        s = s - (MAXV + 1);
`endif
      end
      if (op == 2'd3) macc[i] = s;
      e.res[i*W +: W] = s[W-1:0];
    end
    e.ovf = mdl_ovf;
    sb.push_back(e);
  endtask

  // One clock: observe the handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && bif.out_valid && bif.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: result=%h with no expected beat", bif.result);
      end else begin
        e = sb.pop_front();
        if (bif.result !== e.res) begin
          errors++;
          $display("FAIL sb_result: got %h expected %h", bif.result, e.res);
        end
        checks++;
        if (bif.ovf !== e.ovf) begin
          errors++;
          $display("FAIL sb_ovf: got %b expected %b", bif.ovf, e.ovf);
        end
        checks++;
        if (bif.count !== n_out) begin
          errors++;
          $display("FAIL sb_count: got %0d expected %0d", bif.count, n_out);
        end
      end
      n_out = n_out + 16'd1;
      last_result = bif.result;
    end
    in_fired = 1'b0;
    if (!rst && bif.in_valid && bif.in_ready) begin
      model_push(bif.op, bif.x, bif.y);
      in_fired = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bif.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < L; i++) macc[i] = 0;
    mdl_ovf = 1'b0;
    n_out = 16'd0;
  endtask

  task automatic send(input logic [1:0] op, input logic [L*W-1:0] xv, input logic [L*W-1:0] yv);
    int n;
    bif.op = op;
    bif.x = xv;
    bif.y = yv;
    bif.in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_fired && n < 200);
    bif.in_valid = 1'b0;
    if (!in_fired) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat op=%0d not accepted", op);
    end
  endtask

  task automatic drain();
    int n;
    bif.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", sb.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b0;
    bif.op = 2'd0;
    bif.x = '0;
    bif.y = '0;
    tick();
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bif.in_ready); end
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid); end
    checks++;
    if (bif.result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", bif.result); end
    checks++;
    if (bif.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bif.ovf); end
    checks++;
    if (bif.count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bif.count); end
    apply_reset();
  endtask

  task automatic test_sum_latency();
    apply_reset();
    bif.out_ready = 1'b1;
    bif.op = 2'd0;
    bif.x = {8'd1, 8'd2};
    bif.y = {8'd2, 8'd3};
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    checks++;
    if (in_fired !== 1'b1) begin errors++; $display("FAIL sum_accept: got %b expected 1", in_fired); end
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL sum_lat_early: out_valid %b expected 0", bif.out_valid); end
    tick();
    checks++;
    if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL sum_lat_valid: out_valid %b expected 1", bif.out_valid); end
    checks++;
    if (bif.result !== {8'd3, 8'd5}) begin errors++; $display("FAIL sum_result: got %h expected 0305", bif.result); end
    tick();
    checks++;
    if (bif.count !== 16'd1) begin errors++; $display("FAIL sum_count: got %0d expected 1", bif.count); end
    checks++;
    if (bif.ovf !== 1'b0) begin errors++; $display("FAIL sum_ovf: got %b expected 0", bif.ovf); end
  endtask

  task automatic test_overflow();
    apply_reset();
    bif.out_ready = 1'b1;
    send(2'd0, {8'd0, 8'd200}, {8'd0, 8'd100});
    drain();
    checks++;
`ifdef TFCALL_SAT_EN
    if (last_result !== {8'd0, 8'd255}) begin errors++; $display("FAIL ovf_result: got %h expected 00ff", last_result); end
`else
    if (last_result !== {8'd0, 8'd44}) begin errors++; $display("FAIL ovf_result: got %h expected 002c", last_result); end
`endif
    send(2'd0, {8'd1, 8'd1}, {8'd1, 8'd1});
    send(2'd1, {8'd3, 8'd4}, '0);
    drain();
    checks++;
    if (bif.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bif.ovf); end
  endtask

  task automatic test_back_to_back_acc();
    apply_reset();
    bif.out_ready = 1'b1;
    send(2'd3, {8'd10, 8'd10}, '0);
    send(2'd3, {8'd10, 8'd10}, '0);
    send(2'd3, {8'd10, 8'd10}, '0);
    send(2'd2, {8'd77, 8'd99}, '0);
    send(2'd3, {8'd0, 8'd0}, '0);
    drain();
    checks++;
    if (last_result !== {8'd30, 8'd30}) begin errors++; $display("FAIL acc_final: got %h expected 1e1e", last_result); end
    checks++;
    if (bif.count !== 16'd5) begin errors++; $display("FAIL acc_count: got %0d expected 5", bif.count); end
  endtask

  task automatic test_backpressure();
    int idx;
    logic [7:0] v;
    apply_reset();
    bif.out_ready = 1'b0;
    bif.op = 2'd1;
    bif.y = '0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      v = 8'(idx + 1);
      bif.x = {v, v};
      bif.in_valid = 1'b1;
      tick();
      if (in_fired) idx++;
    end
    bif.in_valid = 1'b0;
    checks++;
    if (idx !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", idx); end
    checks++;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", bif.in_ready); end
    checks++;
    if (bif.result !== {8'd2, 8'd2}) begin errors++; $display("FAIL bp_hold: got %h expected 0202", bif.result); end
    bif.out_ready = 1'b1;
    for (int k = idx; k < 4; k++) begin
      v = 8'(k + 1);
      send(2'd1, {v, v}, '0);
    end
    drain();
    checks++;
    if (bif.count !== 16'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", bif.count); end
    checks++;
    if (last_result !== {8'd8, 8'd8}) begin errors++; $display("FAIL bp_last: got %h expected 0808", last_result); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bif.out_ready = 1'b0;
    bif.op = 2'd3;
    bif.x = {8'd5, 8'd5};
    bif.y = '0;
    bif.in_valid = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: in_ready %b expected 0", bif.in_ready); end
    rst = 1'b1;
    tick();
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bif.out_valid); end
    checks++;
    if (bif.count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", bif.count); end
    checks++;
    if (bif.ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", bif.ovf); end
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bif.in_ready); end
    bif.in_valid = 1'b0;
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < L; i++) macc[i] = 0;
    mdl_ovf = 1'b0;
    n_out = 16'd0;
    tick();
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_ghost: out_valid %b expected 0", bif.out_valid); end
    bif.out_ready = 1'b1;
    send(2'd3, {8'd7, 8'd7}, '0);
    drain();
    checks++;
    if (last_result !== {8'd7, 8'd7}) begin errors++; $display("FAIL mid_acc_cleared: got %h expected 0707", last_result); end
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    apply_reset();
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!bif.in_valid && $urandom_range(0, 3) != 0) begin
        bif.op = 2'($urandom_range(0, 3));
        bif.x = 16'($urandom());
        bif.y = 16'($urandom());
        bif.in_valid = 1'b1;
      end
      bif.out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (in_fired) begin
        sent++;
        bif.in_valid = 1'b0;
      end
    end
    bif.in_valid = 1'b0;
    checks++;
    if (sent != 1000) begin errors++; $display("FAIL rand_sent: got %0d expected 1000", sent); end
    drain();
    checks++;
    if (bif.count !== n_out) begin errors++; $display("FAIL rand_count: got %0d expected %0d", bif.count, n_out); end
    checks++;
    if (n_out !== 16'd1000) begin errors++; $display("FAIL rand_transfers: got %0d expected 1000", n_out); end
  endtask

  initial begin
    for (int i = 0; i < L; i++) macc[i] = 0;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b0;
    bif.op = 2'd0;
    bif.x = '0;
    bif.y = '0;
    test_reset();
    test_sum_latency();
    test_overflow();
    test_back_to_back_acc();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
